// File: rtl/sic_alu_lock_arbiter_pkg.sv
// Shared types and the issue-id age comparison used by the SIC ALU lock arbiter.
package sic_alu_lock_arbiter_pkg;

  localparam int ALU_ID_WIDTH = 6;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'd0,
    ALU_SUBU = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_LUI  = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic                    req;
    logic [ALU_ID_WIDTH-1:0] req_issue_id;
    logic                    release_lock;
  } alu_rpl_t;

  typedef struct packed {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] c;
    logic        zero;
  } alu_ans_t;

  // a is older than b when the modular distance a-b lands in the upper half
  function automatic logic is_older(input logic [ALU_ID_WIDTH-1:0] a,
                                    input logic [ALU_ID_WIDTH-1:0] b);
    logic [ALU_ID_WIDTH-1:0] diff;
    diff = a - b;
    return diff[ALU_ID_WIDTH-1];
  endfunction

endpackage

// File: rtl/sic_alu_lock_arbiter_alu_core.sv
// Combinational integer ALU: op/a/b -> c/zero. Undefined opcodes return 0.
module alu_core
  import sic_alu_lock_arbiter_pkg::*;
(
  input  alu_op_t     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] c_o,
  output logic        zero_o
);

  always_comb begin
    c_o = 32'h0;
    case (op_i)
      ALU_ADDU: c_o = a_i + b_i;
      ALU_SUBU: c_o = a_i - b_i;
      ALU_AND:  c_o = a_i & b_i;
      ALU_OR:   c_o = a_i | b_i;
      ALU_XOR:  c_o = a_i ^ b_i;
      ALU_NOR:  c_o = ~(a_i | b_i);
      ALU_SLT:  c_o = {31'h0, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: c_o = {31'h0, (a_i < b_i)};
      ALU_LUI:  c_o = {b_i[15:0], 16'h0};
      ALU_SLL:  c_o = b_i << a_i[4:0];
      ALU_SRL:  c_o = b_i >> a_i[4:0];
      ALU_SRA:  c_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      default:  c_o = 32'h0;
    endcase
  end

  assign zero_o = (c_o == 32'h0);

endmodule

// File: rtl/sic_alu_lock_arbiter.sv
// Oldest-issue-id ALU lock arbiter for the SIC array.
// Optional forced-release watchdog: define SIC_ALU_ARB_WATCHDOG_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | no owner; arbitrate any raised req
//   ST_LOCKED | owner_q holds the ALU until its release_lock
module sic_alu_lock_arbiter
  import sic_alu_lock_arbiter_pkg::*;
#(
  parameter int NUM_SICS = 4,
  parameter int ID_WIDTH = ALU_ID_WIDTH,
  parameter int WD_LIMIT = 64
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  alu_rpl_t                                           rpl     [NUM_SICS],
  input  alu_req_t                                           alu_req [NUM_SICS],
  output logic [NUM_SICS-1:0]                                alu_grant,
  output alu_ans_t                                           alu_ans,
  output logic                                               locked,
  output logic [((NUM_SICS > 1) ? $clog2(NUM_SICS) : 1)-1:0] owner,
  output logic                                               wd_fire
);

  localparam int OW = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic                win_valid;
  logic [OW-1:0]       win_idx;
  logic [ID_WIDTH-1:0] win_id;
  logic                release_hit;
  logic                wd_expire;
  logic [OW-1:0]       ans_sel;

  assign locked      = (state_q == ST_LOCKED);
  assign owner       = owner_q;
  assign release_hit = locked && rpl[owner_q].release_lock;

  // Linear oldest-first reduction; strict compare keeps the lower index on ties.
  // While locked the owner is excluded so a release can hand off directly.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_id    = '0;
    for (int i = 0; i < NUM_SICS; i++) begin
      if (rpl[i].req && !(locked && (OW'(i) == owner_q))) begin
        if (!win_valid || is_older(rpl[i].req_issue_id, win_id)) begin
          win_valid = 1'b1;
          win_idx   = OW'(i);
          win_id    = rpl[i].req_issue_id;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_LOCKED;
          owner_d = win_idx;
        end
      end
      ST_LOCKED: begin
        if (release_hit) begin
          if (win_valid) begin
            owner_d = win_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    alu_grant = '0;
    if (locked) alu_grant[owner_q] = 1'b1;
  end

  assign ans_sel = locked ? owner_q : '0;

  alu_core u_alu_core (
    .op_i   (alu_req[ans_sel].op),
    .a_i    (alu_req[ans_sel].a),
    .b_i    (alu_req[ans_sel].b),
    .c_o    (alu_ans.c),
    .zero_o (alu_ans.zero)
  );

`ifdef SIC_ALU_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_fire_q;
  logic            wd_starve;

  assign wd_starve = locked && !rpl[owner_q].req && !release_hit;
  assign wd_expire = wd_starve && (wd_cnt_q == WD_W'(WD_LIMIT - 1));
  assign wd_cnt_d  = (wd_starve && !wd_expire) ? wd_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      wd_fire_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      wd_fire_q <= wd_expire;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && wd_expire) $error("ALU lock watchdog forced release of SIC %0d", owner_q);
  end
`endif

  assign wd_fire = wd_fire_q;
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = ^WD_LIMIT;
  assign wd_expire     = 1'b0;
  assign wd_fire       = 1'b0;
`endif

endmodule

// File: tb/tb_sic_alu_lock_arbiter.sv
// Directed self-checking bench for sic_alu_lock_arbiter (4 SICs, 6-bit ids).
module tb_sic_alu_lock_arbiter;
  import sic_alu_lock_arbiter_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  alu_rpl_t       rpl     [4];
  alu_req_t       alu_req [4];
  logic [3:0]     alu_grant;
  alu_ans_t       alu_ans;
  logic           locked;
  logic [1:0]     owner;
  logic           wd_fire;
  int             checks = 0;
  int             errors = 0;

  sic_alu_lock_arbiter #(.NUM_SICS(4), .ID_WIDTH(6), .WD_LIMIT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rpl       (rpl),
    .alu_req   (alu_req),
    .alu_grant (alu_grant),
    .alu_ans   (alu_ans),
    .locked    (locked),
    .owner     (owner),
    .wd_fire   (wd_fire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rpl(input int i, input logic req, input logic [5:0] id, input logic rel);
    rpl[i].req          = req;
    rpl[i].req_issue_id = id;
    rpl[i].release_lock = rel;
  endtask

  task automatic set_req(input int i, input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    alu_req[i].op = op;
    alu_req[i].a  = a;
    alu_req[i].b  = b;
  endtask

  task automatic chk_lock(input string tag, input logic lk, input logic [1:0] own, input logic [3:0] gnt);
    chk({tag, "_locked"}, {31'h0, locked}, {31'h0, lk});
    chk({tag, "_owner"},  {30'h0, owner},  {30'h0, own});
    chk({tag, "_grant"},  {28'h0, alu_grant}, {28'h0, gnt});
  endtask

  task automatic chk_ans(input string tag, input logic [31:0] c, input logic z);
    chk({tag, "_c"},    alu_ans.c, c);
    chk({tag, "_zero"}, {31'h0, alu_ans.zero}, {31'h0, z});
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      set_rpl(i, 1'b0, 6'd0, 1'b0);
      set_req(i, ALU_ADDU, 32'h0, 32'h0);
    end
    set_req(0, ALU_ADDU, 32'd1, 32'd2);
    #2;
    chk_lock("reset", 1'b0, 2'd0, 4'b0000);
    chk("reset_wd_fire", {31'h0, wd_fire}, 32'h0);
    chk_ans("reset_ans_req0", 32'd3, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // single requester
    set_rpl(1, 1'b1, 6'd5, 1'b0);
    set_req(1, ALU_ADDU, 32'd7, 32'd9);
    chk_lock("single_pre", 1'b0, 2'd0, 4'b0000);
    step();
    chk_lock("single", 1'b1, 2'd1, 4'b0010);
    chk_ans("single_addu", 32'd16, 1'b0);
    set_rpl(1, 1'b0, 6'd5, 1'b1);
    step();
    set_rpl(1, 1'b0, 6'd5, 1'b0);
    chk_lock("single_rel", 1'b0, 2'd1, 4'b0000);

    // age priority and back-to-back handoff
    set_rpl(0, 1'b1, 6'd10, 1'b0);
    set_rpl(2, 1'b1, 6'd3, 1'b0);
    set_req(2, ALU_SUBU, 32'h1234, 32'h1234);
    set_req(0, ALU_SRA, 32'd4, 32'h8000_0000);
    step();
    chk_lock("age", 1'b1, 2'd2, 4'b0100);
    chk_ans("subu_eq", 32'h0, 1'b1);
    set_rpl(2, 1'b0, 6'd3, 1'b1);
    step();
    set_rpl(2, 1'b0, 6'd3, 1'b0);
    chk_lock("handoff", 1'b1, 2'd0, 4'b0001);
    chk_ans("sra", 32'hF800_0000, 1'b0);

    // non-owner abort is ignored
    set_rpl(3, 1'b1, 6'd20, 1'b0);
    step();
    chk_lock("abort_req", 1'b1, 2'd0, 4'b0001);
    set_rpl(3, 1'b0, 6'd20, 1'b1);
    step();
    set_rpl(3, 1'b0, 6'd20, 1'b0);
    chk_lock("abort_rel", 1'b1, 2'd0, 4'b0001);
    set_rpl(0, 1'b0, 6'd10, 1'b1);
    step();
    set_rpl(0, 1'b0, 6'd10, 1'b0);
    chk_lock("owner0_rel", 1'b0, 2'd0, 4'b0000);

    // wrap-around age compare
    set_rpl(0, 1'b1, 6'd62, 1'b0);
    set_rpl(1, 1'b1, 6'd1, 1'b0);
    step();
    chk_lock("wrap", 1'b1, 2'd0, 4'b0001);
    set_rpl(0, 1'b0, 6'd62, 1'b1);
    step();
    set_rpl(0, 1'b0, 6'd62, 1'b0);
    chk_lock("wrap_handoff", 1'b1, 2'd1, 4'b0010);
    set_rpl(1, 1'b0, 6'd1, 1'b1);
    step();
    set_rpl(1, 1'b0, 6'd1, 1'b0);
    chk_lock("wrap_rel", 1'b0, 2'd1, 4'b0000);

    // equal ids: lower index wins
    set_rpl(3, 1'b1, 6'd7, 1'b0);
    set_rpl(1, 1'b1, 6'd7, 1'b0);
    step();
    chk_lock("equal_id", 1'b1, 2'd1, 4'b0010);

    // op sweep on the owner's operands
    set_req(1, ALU_LUI, 32'h0, 32'h1234_ABCD);        #1; chk_ans("lui",  32'hABCD_0000, 1'b0);
    set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);        #1; chk_ans("slt",  32'd1, 1'b0);
    set_req(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);       #1; chk_ans("sltu", 32'd0, 1'b1);
    set_req(1, ALU_NOR, 32'h0, 32'h0);                #1; chk_ans("nor",  32'hFFFF_FFFF, 1'b0);
    set_req(1, ALU_SLL, 32'd4, 32'd1);                #1; chk_ans("sll",  32'd16, 1'b0);
    set_req(1, ALU_SRL, 32'd4, 32'h8000_0000);        #1; chk_ans("srl",  32'h0800_0000, 1'b0);
    set_req(1, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF); #1; chk_ans("and",  32'h00F0_1234, 1'b0);
    set_req(1, ALU_OR,  32'hF000_0000, 32'h0000_000F); #1; chk_ans("or",   32'hF000_000F, 1'b0);
    set_req(1, ALU_XOR, 32'hFFFF_0000, 32'hFF00_FF00); #1; chk_ans("xor",  32'h00FF_FF00, 1'b0);
    set_req(1, ALU_SUBU, 32'd0, 32'd1);               #1; chk_ans("subu_wrap", 32'hFFFF_FFFF, 1'b0);
    set_req(1, alu_op_t'(4'd13), 32'd5, 32'd6);       #1; chk_ans("undef", 32'h0, 1'b1);

    set_rpl(1, 1'b0, 6'd7, 1'b1);
    step();
    set_rpl(1, 1'b0, 6'd7, 1'b0);
    chk_lock("equal_handoff", 1'b1, 2'd3, 4'b1000);
    set_rpl(3, 1'b0, 6'd7, 1'b1);
    step();
    set_rpl(3, 1'b0, 6'd7, 1'b0);
    chk_lock("equal_rel", 1'b0, 2'd3, 4'b0000);

    // reset mid-lock
    set_rpl(2, 1'b1, 6'd9, 1'b0);
    step();
    chk_lock("pre_reset", 1'b1, 2'd2, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_lock("mid_reset", 1'b0, 2'd0, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
    chk_lock("post_reset", 1'b1, 2'd2, 4'b0100);

`ifdef SIC_ALU_ARB_WATCHDOG_EN
    // owner stalls without release; SIC0 waits
    set_rpl(2, 1'b0, 6'd9, 1'b0);
    set_rpl(0, 1'b1, 6'd30, 1'b0);
    for (int k = 0; k < 7; k++) step();
    chk_lock("wd_hold", 1'b1, 2'd2, 4'b0100);
    chk("wd_quiet", {31'h0, wd_fire}, 32'h0);
    step();
    chk_lock("wd_fire_lock", 1'b0, 2'd2, 4'b0000);
    chk("wd_fire", {31'h0, wd_fire}, 32'h1);
    step();
    chk_lock("wd_next", 1'b1, 2'd0, 4'b0001);
    chk("wd_pulse_end", {31'h0, wd_fire}, 32'h0);
    set_rpl(0, 1'b0, 6'd30, 1'b1);
    step();
    set_rpl(0, 1'b0, 6'd30, 1'b0);
`else
    set_rpl(2, 1'b0, 6'd9, 1'b0);
    for (int k = 0; k < 10; k++) step();
    chk_lock("stall_hold", 1'b1, 2'd2, 4'b0100);
    chk("no_wd_fire", {31'h0, wd_fire}, 32'h0);
    set_rpl(2, 1'b0, 6'd9, 1'b1);
    step();
    set_rpl(2, 1'b0, 6'd9, 1'b0);
    chk_lock("stall_rel", 1'b0, 2'd2, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sic_alu_lock_arbiter.md
Name: sic_alu_lock_arbiter

Overview:
- Responder side of the SIC ALU lock protocol.
- Arbitrates one shared ALU among NUM_SICS execution sub-units; oldest issue_id wins.
- Holds the lock for the winner until that SIC's release pulse, and drives ALU results computed from the owner's request back to all SICs.
- Sits between the SIC array and the single integer ALU.

Parameters:
- NUM_SICS, 4, number of requesting SIC sub-units (>=1).
- ID_WIDTH, 6, issue_id width; ids compare modulo 2^ID_WIDTH.
- WD_LIMIT, 64, watchdog cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rpl  in  NUM_SICS x alu_rpl_t  per-SIC {req, req_issue_id[ID_WIDTH], release_lock}
- alu_req  in  NUM_SICS x alu_req_t  per-SIC {op: alu_op_t, a[32], b[32]}
- alu_grant  out  NUM_SICS  per-SIC grant; one-hot or zero
- alu_ans  out  alu_ans_t  {c[32], zero}; valid only for the granted SIC
- locked  out  1  lock currently held
- owner  out  clog2(NUM_SICS) (min 1)  index of the current owner
- wd_fire  out  1  watchdog forced-release pulse; tied 0 when the feature is off

Behaviour:
- Reset values: state=IDLE, owner=0, alu_grant=0, locked=0, wd_fire=0. alu_ans is combinational; with no grant it computes from alu_req[0].
- State machine IDLE -> LOCKED:
  - IDLE: if any rpl[i].req is set, register winner into owner; next state LOCKED. Grant is registered: alu_grant[owner]=1 from the cycle after arbitration, for as long as the state is LOCKED.
  - LOCKED -> IDLE on rpl[owner].release_lock.
  - release_lock from any non-owner is ignored, covering SICs that abort before being granted.
- Back-to-back handoff: in the release cycle the arbiter also arbitrates among the other requesters (owner's req is ignored that cycle). A winner goes straight to LOCKED with the new owner, so the new grant starts the next cycle and there is no idle bubble.
- Age rule: i is older than j iff (id_i - id_j) mod 2^ID_WIDTH has its MSB set. Equal ids: lower index wins. Selection is a combinational linear reduction over requesters.
- Owner lowering req without a release (abort path): the lock is held until the release arrives. The SIC always pulses release when it needed the ALU.
- Results are combinational from alu_req[owner], zero latency. The SIC commits in the same cycle it sees the grant.
- ALU ops (alu_op_t):
  - ADDU, SUBU: 32-bit wrap, no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT: signed compare; SLTU: unsigned compare; result is 1 or 0.
  - LUI: c = {b[15:0], 16'h0}.
  - SLL, SRL, SRA: shift b by a[4:0].
  - Undefined op: c=0.
  - zero = (c == 32'h0). Branches use SUBU and zero.
- Reset mid-lock: immediately returns to IDLE with grant=0. No pending state survives reset.

Optional Feature:
- Macro SIC_ALU_ARB_WATCHDOG_EN.
- Enabled:
  - A counter increments each LOCKED cycle in which rpl[owner].req=0 and no release arrives; it clears on any other cycle.
  - When it reaches WD_LIMIT: force LOCKED -> IDLE, pulse wd_fire for 1 cycle, and raise an $error in simulation.
- Disabled: no counter, wd_fire tied 0, the lock is held indefinitely.

Decomposition:
- Shared package (structs.svh / common package): alu_op_t enum, alu_rpl_t, alu_req_t, alu_ans_t, and the age-compare function is_older(a, b).
- Sub-module alu_core: purely combinational op/a/b -> c/zero, reusable by other execution units.
- Arbitration, lock FSM, and the optional watchdog stay in sic_alu_lock_arbiter.

Test Plan:
- Single requester SIC1 (id=5, ADDU a=7 b=9): grant[1]=1 on the cycle after req, c=16, zero=0. SIC1 pulses release -> locked=0 next cycle.
- Age priority: SIC0 id=10 and SIC2 id=3 request in the same cycle -> owner=2. After SIC2's release, SIC0 is granted with no idle cycle.
- Wrap-around: ID_WIDTH=6, SIC0 id=62 and SIC1 id=1 -> SIC0 wins (62 is older than 1 across the wrap). Equal ids 7/7 on SIC1/SIC3 -> SIC1 wins.
- Ops and abort:
  - SUBU a=b=0x1234 -> zero=1.
  - SRA b=0x80000000 by a=4 -> c=0xF8000000.
  - SIC3 requests, drops req and pulses release while SIC0 owns the lock -> SIC0's lock unaffected.
- Reset mid-lock: assert rst_n=0 while SIC2 is owner -> grant=0 and locked=0 immediately. After reset, a new request is granted normally.
- With SIC_ALU_ARB_WATCHDOG_EN and WD_LIMIT=8: owner drops req with no release -> after 8 cycles wd_fire pulses, locked=0, and a pending SIC is granted next.
